dot_fp8_seq: RTL and testbench

- Sequencer for the combinational dot_fp8 datapath; computes dot products over vectors longer than k.
- Accepts a stream of k-element FP8 chunk pairs over a valid/ready handshake and registers each chunk onto the datapath operand bus.
- Accumulates the per-chunk fixed-point results, with a sticky NaN flag, into one wide sum.
- Returns the sum over an output valid/ready handshake. It sits between the block-operand fetch logic and the MX scale/normalise stage.

---
 rtl/dot_fp8_seq.sv | 158 +++++++++++++++
 tb/tb_dot_fp8_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_fp8_seq.sv
// dot_fp8_seq: sequencer for the combinational dot_fp8 datapath.
//
// Long FP8 dot products arrive as a stream of k-element chunk pairs. Each
// accepted chunk is registered onto the datapath operand bus (o_dp_a/o_dp_b).
// The datapath answers combinationally on i_dp/i_dp_nan in the following
// cycle, and that answer is folded into a wide signed accumulator with a
// sticky NaN flag. The finished sum is presented on an output valid/ready
// handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_len             chunk count of the dot product (first beat only)
//   i_valid, o_ready  chunk beat handshake (o_ready depends only on state)
//   i_vec_a, i_vec_b  chunk operands, k packed elements, element 0 in the LSBs
//   o_dp_a, o_dp_b    registered operands driven to the datapath
//   i_dp, i_dp_nan    datapath result and NaN flag for o_dp_a/o_dp_b
//   o_valid, i_ready  result handshake (o_valid depends only on state)
//   o_acc, o_nan      accumulated signed sum, LSB = min-subnormal squared
module dot_fp8_seq #(
    parameter int exp_width  = 4,
    parameter int man_width  = 3,
    parameter int k          = 32,
    parameter int e4m3_spec  = 1,
    parameter int max_blocks = 16,
    parameter int bit_width  = 1 + exp_width + man_width,
    parameter int dp_width   = 2 * ((1 << exp_width) + man_width) + $clog2(k),
    parameter int acc_width  = dp_width + $clog2(max_blocks),
    parameter int len_width  = $clog2(max_blocks + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [len_width-1:0]        i_len,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [k*bit_width-1:0]      i_vec_a,
    input  logic [k*bit_width-1:0]      i_vec_b,
    output logic [k*bit_width-1:0]      o_dp_a,
    output logic [k*bit_width-1:0]      o_dp_b,
    input  logic signed [dp_width-1:0]  i_dp,
    input  logic                        i_dp_nan,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [acc_width-1:0] o_acc,
    output logic                        o_nan
);

    // NaN decoding lives in the datapath; the encoding choice only has to be
    // a legal value here.
    if (e4m3_spec != 0 && e4m3_spec != 1) begin : g_bad_e4m3_spec
        $error("dot_fp8_seq: e4m3_spec must be 0 or 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                       state_reg;
    logic [len_width-1:0]         cnt_reg;
    logic [len_width-1:0]         eff_len_reg;
    logic [len_width-1:0]         len_eff;
    logic [len_width-1:0]         cnt_next;
    logic                         s1_v_reg;
    logic                         first_reg;
    logic                         nan_reg;
    logic signed [acc_width-1:0]  acc_reg;
    logic signed [acc_width-1:0]  dp_ext;
    logic                         beat;

    logic [bit_width-1:0] dp_a_reg [k];
    logic [bit_width-1:0] dp_b_reg [k];

    assign o_ready  = (state_reg == IDLE) || (state_reg == RUN);
    assign o_valid  = (state_reg == OUT);
    assign o_acc    = acc_reg;
    assign o_nan    = nan_reg;
    assign beat     = i_valid && o_ready;
    assign cnt_next = cnt_reg + len_width'(1);
    assign dp_ext   = {{(acc_width - dp_width){i_dp[dp_width-1]}}, i_dp};

    // Zero-length requests still run one chunk; oversize requests clamp.
    always_comb begin
        len_eff = i_len;
        if (i_len == '0) begin
            len_eff = len_width'(1);
        end else if (i_len > len_width'(max_blocks)) begin
            len_eff = len_width'(max_blocks);
        end
    end

    // Operand registers: one lane per element, loaded only on an accepted
    // beat so the datapath inputs hold steady through bubbles.
    for (genvar gi = 0; gi < k; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                dp_a_reg[gi] <= '0;
                dp_b_reg[gi] <= '0;
            end else if (beat) begin
                dp_a_reg[gi] <= i_vec_a[gi*bit_width +: bit_width];
                dp_b_reg[gi] <= i_vec_b[gi*bit_width +: bit_width];
            end
        end
        assign o_dp_a[gi*bit_width +: bit_width] = dp_a_reg[gi];
        assign o_dp_b[gi*bit_width +: bit_width] = dp_b_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            eff_len_reg <= '0;
            s1_v_reg    <= 1'b0;
            first_reg   <= 1'b0;
            acc_reg     <= '0;
            nan_reg     <= 1'b0;
        end else begin
            // s1_v marks that the operand registers hold a fresh chunk, so
            // i_dp this cycle belongs to it.
            s1_v_reg <= beat;

            // The first chunk of a transaction overwrites rather than adds,
            // so the previous result stays visible in IDLE until then.
            if (s1_v_reg) begin
                acc_reg   <= (first_reg ? '0 : acc_reg) + dp_ext;
                nan_reg   <= (first_reg ? 1'b0 : nan_reg) | i_dp_nan;
                first_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (beat) begin
                        eff_len_reg <= len_eff;
                        cnt_reg     <= len_width'(1);
                        first_reg   <= 1'b1;
                        state_reg   <= (len_eff == len_width'(1)) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        cnt_reg <= cnt_next;
                        if (cnt_next == eff_len_reg) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last chunk accumulates during this cycle.
                    state_reg <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_fp8_seq.sv
module tb_dot_fp8_seq;

    localparam int K    = 32;
    localparam int BW   = 8;
    localparam int DPW  = 43;
    localparam int ACCW = 47;
    localparam int LW   = 5;
    localparam int VW   = K * BW;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [LW-1:0]          i_len = '0;
    logic                   i_valid = 1'b0;
    logic                   o_ready;
    logic [VW-1:0]          i_vec_a = '0;
    logic [VW-1:0]          i_vec_b = '0;
    logic [VW-1:0]          o_dp_a;
    logic [VW-1:0]          o_dp_b;
    logic signed [DPW-1:0]  i_dp;
    logic                   i_dp_nan;
    logic                   o_valid;
    logic                   i_ready = 1'b0;
    logic signed [ACCW-1:0] o_acc;
    logic                   o_nan;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dot_fp8_seq dut (
        .clk      (clk),
        .rst      (rst),
        .i_len    (i_len),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_vec_a  (i_vec_a),
        .i_vec_b  (i_vec_b),
        .o_dp_a   (o_dp_a),
        .o_dp_b   (o_dp_b),
        .i_dp     (i_dp),
        .i_dp_nan (i_dp_nan),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_acc    (o_acc),
        .o_nan    (o_nan)
    );

    // Reference E4M3 datapath: each element as a signed integer in units of
    // the minimum subnormal (2^-9), so a product is in units of 2^-18.
    function automatic longint fp8_val(input logic [7:0] x);
        longint mag;
        if (x[6:3] == 4'd0) mag = longint'(x[2:0]);
        else                mag = longint'({1'b1, x[2:0]}) << (x[6:3] - 4'd1);
        return x[7] ? -mag : mag;
    endfunction

    longint dp_sum;
    logic   dp_nan_any;
    always_comb begin
        dp_sum     = 0;
        dp_nan_any = 1'b0;
        for (int i = 0; i < K; i++) begin
            dp_sum     = dp_sum + fp8_val(o_dp_a[i*BW +: BW]) * fp8_val(o_dp_b[i*BW +: BW]);
            dp_nan_any = dp_nan_any | (o_dp_a[i*BW +: 7] == 7'h7F) | (o_dp_b[i*BW +: 7] == 7'h7F);
        end
    end
    assign i_dp     = DPW'(dp_sum);
    assign i_dp_nan = dp_nan_any;

    function automatic logic [VW-1:0] fill(input logic [7:0] v);
        return {K{v}};
    endfunction

    // Presents one chunk at a negedge, holds it across one posedge, returns
    // at the following negedge with i_valid dropped.
    task automatic beat(input logic [LW-1:0] len, input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int w = 0; w < 20 && !o_ready; w++) @(negedge clk);
        if (!o_ready) begin
            n_vec++; n_miss++;
            $display("FAIL beat_ready_timeout o_ready=%b required=1", o_ready);
        end
        i_valid = 1'b1; i_len = len; i_vec_a = a; i_vec_b = b;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_vec++; if (o_ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready got=%b want=1", o_ready); end
        n_vec++; if (o_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        n_vec++; if (o_acc !== '0) begin n_miss++; $display("FAIL reset_acc got=%0d want=0", o_acc); end
        n_vec++; if (o_nan !== 1'b0) begin n_miss++; $display("FAIL reset_nan got=%b want=0", o_nan); end
        n_vec++; if (o_dp_a !== '0 || o_dp_b !== '0) begin n_miss++; $display("FAIL reset_dp got=%h/%h want=0", o_dp_a, o_dp_b); end
        $display("txn reset done");
    endtask

    task automatic test_single();
        beat(1, fill(8'h38), fill(8'h38));
        n_vec++; if (o_valid !== 1'b0) begin n_miss++; $display("FAIL single_early got=%b want=0", o_valid); end
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL single_latency got=%b want=1", o_valid); end
        n_vec++; if (o_acc !== 47'sd8388608) begin n_miss++; $display("FAIL single_acc got=%0d want=8388608", o_acc); end
        n_vec++; if (o_nan !== 1'b0) begin n_miss++; $display("FAIL single_nan got=%b want=0", o_nan); end
        $display("txn single len=1 acc=%0d nan=%b", o_acc, o_nan);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
        n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_miss++; $display("FAIL single_consume valid=%b ready=%b want 0/1", o_valid, o_ready); end
    endtask

    task automatic test_bubbles();
        beat(4, fill(8'h38), fill(8'h38));
        beat(4, fill(8'h38), fill(8'h38));
        repeat (2) @(negedge clk);
        n_vec++; if (o_ready !== 1'b1) begin n_miss++; $display("FAIL bubble_ready got=%b want=1", o_ready); end
        beat(4, fill(8'h38), fill(8'h38));
        beat(4, fill(8'h38), fill(8'h38));
        n_vec++; if (o_valid !== 1'b0) begin n_miss++; $display("FAIL bubble_early got=%b want=0", o_valid); end
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL bubble_latency got=%b want=1", o_valid); end
        n_vec++; if (o_acc !== 47'sd33554432) begin n_miss++; $display("FAIL bubble_acc got=%0d want=33554432", o_acc); end
        $display("txn bubbles len=4 acc=%0d nan=%b", o_acc, o_nan);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    endtask

    task automatic test_mixed();
        logic [VW-1:0] a_nan;
        logic signed [ACCW-1:0] want;
        want = -47'sd8388544;
        beat(3, fill(8'hB8), fill(8'h38));
        beat(3, fill(8'h01), fill(8'h01));
        beat(3, fill(8'h01), fill(8'h01));
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL mixed_latency got=%b want=1", o_valid); end
        n_vec++; if (o_acc !== want) begin n_miss++; $display("FAIL mixed_acc got=%0d want=%0d", o_acc, want); end
        n_vec++; if (o_nan !== 1'b0) begin n_miss++; $display("FAIL mixed_nan got=%b want=0", o_nan); end
        $display("txn mixed len=3 acc=%0d nan=%b", o_acc, o_nan);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;

        a_nan = fill(8'h01);
        a_nan[5*BW +: BW] = 8'h7F;
        beat(3, fill(8'hB8), fill(8'h38));
        beat(3, a_nan, fill(8'h01));
        beat(3, fill(8'h01), fill(8'h01));
        @(negedge clk);
        n_vec++; if (o_nan !== 1'b1 || o_valid !== 1'b1) begin n_miss++; $display("FAIL mixed_nan_sticky nan=%b valid=%b want 1/1", o_nan, o_valid); end
        $display("txn nan len=3 nan=%b", o_nan);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;

        beat(1, fill(8'h00), fill(8'h00));
        @(negedge clk);
        n_vec++; if (o_acc !== '0) begin n_miss++; $display("FAIL zero_acc got=%0d want=0", o_acc); end
        n_vec++; if (o_nan !== 1'b0) begin n_miss++; $display("FAIL zero_nan_cleared got=%b want=0", o_nan); end
        $display("txn zero len=1 acc=%0d nan=%b", o_acc, o_nan);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        ok = 1'b0;
        beat(1, fill(8'h38), fill(8'h38));
        for (int w = 0; w < 20 && !ok; w++) begin
            if (o_valid) ok = 1'b1;
            else @(negedge clk);
        end
        n_vec++; if (!ok) begin n_miss++; $display("FAIL bp_valid_timeout got=0 want=1"); end
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_acc !== 47'sd8388608 || o_nan !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_hold cycle=%0d valid=%b ready=%b acc=%0d nan=%b want 1/0/8388608/0", c, o_valid, o_ready, o_acc, o_nan);
            end
            @(negedge clk);
        end
        i_ready = 1'b1;
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL bp_before_accept got=%b want=1", o_valid); end
        @(negedge clk);
        i_ready = 1'b0;
        n_vec++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_miss++; $display("FAIL bp_consume valid=%b ready=%b want 0/1", o_valid, o_ready); end
        $display("txn backpressure len=1 acc=%0d", o_acc);
    endtask

    task automatic test_reset_mid();
        beat(4, fill(8'h38), fill(8'h38));
        beat(4, fill(8'h38), fill(8'h38));
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        n_vec++; if (o_valid !== 1'b0) begin n_miss++; $display("FAIL midrst_valid got=%b want=0", o_valid); end
        n_vec++; if (o_acc !== '0) begin n_miss++; $display("FAIL midrst_acc got=%0d want=0", o_acc); end
        n_vec++; if (o_ready !== 1'b1) begin n_miss++; $display("FAIL midrst_ready got=%b want=1", o_ready); end
        beat(2, fill(8'h38), fill(8'h38));
        beat(2, fill(8'h38), fill(8'h38));
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL midrst_new_valid got=%b want=1", o_valid); end
        n_vec++; if (o_acc !== 47'sd16777216) begin n_miss++; $display("FAIL midrst_new_acc got=%0d want=16777216", o_acc); end
        $display("txn after_reset len=2 acc=%0d", o_acc);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    endtask

    task automatic test_len_edges();
        beat(0, fill(8'h38), fill(8'h38));
        n_vec++; if (o_ready !== 1'b0) begin n_miss++; $display("FAIL len0_ready got=%b want=0", o_ready); end
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL len0_valid got=%b want=1", o_valid); end
        n_vec++; if (o_acc !== 47'sd8388608) begin n_miss++; $display("FAIL len0_acc got=%0d want=8388608", o_acc); end
        $display("txn len0 acc=%0d", o_acc);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;

        for (int c = 0; c < 16; c++) begin
            n_vec++;
            if (o_ready !== 1'b1) begin n_miss++; $display("FAIL len20_ready beat=%0d got=%b want=1", c, o_ready); end
            beat(20, fill(8'h38), fill(8'h38));
        end
        n_vec++; if (o_ready !== 1'b0 || o_valid !== 1'b0) begin n_miss++; $display("FAIL len20_sat ready=%b valid=%b want 0/0", o_ready, o_valid); end
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b1) begin n_miss++; $display("FAIL len20_valid got=%b want=1", o_valid); end
        n_vec++; if (o_acc !== 47'sd134217728) begin n_miss++; $display("FAIL len20_acc got=%0d want=134217728", o_acc); end
        $display("txn len20 acc=%0d", o_acc);
        i_ready = 1'b1; @(negedge clk); i_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_bubbles();
        test_mixed();
        test_backpressure();
        test_reset_mid();
        test_len_edges();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
